mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute ALU. Consumes the ALU result, opcode, funct3, rd and rs2 data.
- For loads and stores it runs a single-outstanding request/acknowledge transaction on the data-memory bus, with byte/half alignment, sign/zero extension and a timeout.
- All other instructions pass the ALU result to writeback with one-cycle latency.
- Produces a registered writeback bundle and back-pressures execute through in_ready.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// The master holds one request at a time and keeps it stable until bus_ack.
interface mem_access_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage sitting after the execute ALU.
// Loads and stores run one outstanding request/acknowledge transaction on the
// data bus with lane alignment, sign/zero extension and a timeout; every other
// instruction forwards the ALU result to writeback one cycle later.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         alu_out,
    input  logic [6:0]          opcode_i,
    input  logic [2:0]          funct3_i,
    input  logic [4:0]          rd_i,
    input  logic [31:0]         rs2_data_i,

    mem_access_stage_if.master  bus,

    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic                wb_we,
    output logic [31:0]         wb_data,
    output logic                wb_err
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter value seen at the edge that ends the last allowed REQ cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t            state;
    state_t            state_next;

    // Decode of the instruction currently presented by execute.
    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              mem_legal;
    logic              reg_write_op;
    logic              start_access;
    logic [3:0]        store_wstrb;
    logic [31:0]       store_wdata;

    // Transaction captured at accept and held for the whole request.
    logic [31:0]       addr_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              store_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              timeout_hit;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_data;

    // Classify the incoming instruction, check alignment/funct3 legality and
    // pre-format store lanes so the bus sees finished values straight from flops.
    always_comb begin
        is_load      = (opcode_i == OP_LOAD);
        is_store     = (opcode_i == OP_STORE);
        is_mem       = is_load || is_store;
        mem_legal    = 1'b0;
        if (is_load) begin
            case (funct3_i)
                3'b000, 3'b100: mem_legal = 1'b1;
                3'b001, 3'b101: mem_legal = ~alu_out[0];
                3'b010:         mem_legal = (alu_out[1:0] == 2'b00);
                default:        mem_legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3_i)
                3'b000:  mem_legal = 1'b1;
                3'b001:  mem_legal = ~alu_out[0];
                3'b010:  mem_legal = (alu_out[1:0] == 2'b00);
                default: mem_legal = 1'b0;
            endcase
        end

        case (funct3_i[1:0])
            2'b00: begin
                store_wstrb = 4'b0001 << alu_out[1:0];
                store_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                store_wstrb = alu_out[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
                store_wstrb = 4'b1111;
                store_wdata = rs2_data_i;
            end
        endcase

        reg_write_op = (rd_i != 5'd0) &&
                       ((opcode_i == OP_REG) || (opcode_i == OP_IMM) ||
                        (opcode_i == OP_LUI) || (opcode_i == OP_AUIPC) ||
                        (opcode_i == OP_JAL) || (opcode_i == OP_JALR));

        start_access = in_valid && is_mem && mem_legal;
    end

    // Timeout fires on the edge ending the TIMEOUT-th REQ cycle; a TIMEOUT of 0 never fires.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
    end

    // State register; reset drops any in-flight request asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter REQ on a legal memory accept, leave on ack or timeout (ack wins).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_access) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.bus_ack || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: bus is driven only while a request is open.
    always_comb begin
        in_ready      = (state == IDLE);
        bus.bus_req   = (state == REQ);
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 32'd0;
        bus.bus_wdata = 32'd0;
        bus.bus_wstrb = 4'd0;
        if (state == REQ) begin
            bus.bus_we    = store_q;
            bus.bus_addr  = {addr_q[31:2], 2'b00};
            bus.bus_wdata = wdata_q;
            bus.bus_wstrb = wstrb_q;
        end
    end

    // Capture the access on accept and count REQ cycles that pass without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            store_q  <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            if (start_access) begin
                addr_q   <= alu_out;
                funct3_q <= funct3_i;
                rd_q     <= rd_i;
                store_q  <= is_store;
                wdata_q  <= is_store ? store_wdata : 32'd0;
                wstrb_q  <= is_store ? store_wstrb : 4'd0;
                wait_cnt <= '0;
            end
        end else if (!bus.bus_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Pick the addressed byte/half of the returned word and extend it per funct3.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_byte = bus.bus_rdata[7:0];
            2'b01:   lane_byte = bus.bus_rdata[15:8];
            2'b10:   lane_byte = bus.bus_rdata[23:16];
            default: lane_byte = bus.bus_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

        case (funct3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = bus.bus_rdata;
        endcase
    end

    // Writeback bundle: one-cycle pulse; rd/data keep their last values between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !is_mem) begin
                        wb_valid <= 1'b1;
                        wb_we    <= reg_write_op;
                        wb_rd    <= rd_i;
                        wb_data  <= alu_out;
                    end else if (in_valid && !mem_legal) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= rd_i;
                        wb_data  <= alu_out;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        wb_valid <= 1'b1;
                        wb_we    <= !store_q && (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= store_q ? addr_q : load_data;
                    end else if (timeout_hit) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= addr_q;
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a transaction-level model predicts
// every output each cycle, and directed scenarios pin literal expectations.
module tb_mem_access_stage;

    localparam int TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] rs2_data_i;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        wb_err;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_out    (alu_out),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .rd_i       (rd_i),
        .rs2_data_i (rs2_data_i),
        .bus        (bus),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_data    (wb_data),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Compare one value and report a failure line with actual and required values.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: tracks whether one access is outstanding and how long it has waited.
    logic        m_busy;
    int          m_waits;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_store;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic        e_valid;
    logic        e_we;
    logic        e_err;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3);
        int          nbytes;
        logic [31:0] val;
        logic [31:0] mask;
        nbytes = 1 << f3[1:0];
        val    = word >> (8 * addr[1:0]);
        if (nbytes < 4) begin
            mask = 32'((64'd1 << (8 * nbytes)) - 64'd1);
            val  = val & mask;
            if (!f3[2] && val[8 * nbytes - 1]) val = val | ~mask;
        end
        return val;
    endfunction

    always @(posedge clk or posedge rst) begin
        int   nbytes;
        logic legal;
        if (rst) begin
            m_busy  = 1'b0; m_waits = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
            m_store = 1'b0; m_f3 = 0; m_rd = 0;
            e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0; e_rd = 0; e_data = 0;
        end else begin
            e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0;
            if (!m_busy) begin
                if (in_valid && (opcode_i == OP_LOAD || opcode_i == OP_STORE)) begin
                    if (opcode_i == OP_LOAD) legal = (funct3_i[1:0] != 2'b11) && (funct3_i != 3'b110);
                    else                     legal = (funct3_i <= 3'd2);
                    nbytes = 1 << funct3_i[1:0];
                    if (legal && (alu_out % nbytes) != 0) legal = 1'b0;
                    if (!legal) begin
                        e_valid = 1'b1; e_err = 1'b1; e_rd = rd_i; e_data = alu_out;
                    end else begin
                        m_busy  = 1'b1;
                        m_waits = 0;
                        m_addr  = alu_out;
                        m_store = (opcode_i == OP_STORE);
                        m_f3    = funct3_i;
                        m_rd    = rd_i;
                        m_wstrb = m_store ? 4'(((1 << nbytes) - 1) << alu_out[1:0]) : 4'd0;
                        if (!m_store)         m_wdata = 32'd0;
                        else if (nbytes == 1) m_wdata = {24'd0, rs2_data_i[7:0]} * 32'h01010101;
                        else if (nbytes == 2) m_wdata = {16'd0, rs2_data_i[15:0]} * 32'h00010001;
                        else                  m_wdata = rs2_data_i;
                    end
                end else if (in_valid) begin
                    e_valid = 1'b1;
                    e_rd    = rd_i;
                    e_data  = alu_out;
                    e_we    = (rd_i != 0) && (opcode_i inside {7'b0110011, 7'b0010011, 7'b0110111,
                                                               7'b0010111, 7'b1101111, 7'b1100111});
                end
            end else begin
                if (bus.bus_ack) begin
                    e_valid = 1'b1;
                    e_rd    = m_rd;
                    e_we    = !m_store && (m_rd != 0);
                    e_data  = m_store ? m_addr : loadValue(bus.bus_rdata, m_addr, m_f3);
                    m_busy  = 1'b0;
                end else begin
                    m_waits++;
                    if (TO != 0 && m_waits == TO) begin
                        e_valid = 1'b1; e_err = 1'b1; e_rd = m_rd; e_data = m_addr;
                        m_busy  = 1'b0;
                    end
                end
            end
        end
    end

    // Every cycle, all outputs must agree with the model.
    always @(negedge clk) begin
        checkOutput("wb_valid", 32'(wb_valid), 32'(e_valid));
        checkOutput("wb_we", 32'(wb_we), 32'(e_we));
        checkOutput("wb_err", 32'(wb_err), 32'(e_err));
        checkOutput("wb_rd", 32'(wb_rd), 32'(e_rd));
        checkOutput("wb_data", wb_data, e_data);
        checkOutput("in_ready", 32'(in_ready), 32'(!m_busy));
        checkOutput("bus_req", 32'(bus.bus_req), 32'(m_busy));
        checkOutput("bus_we", 32'(bus.bus_we), 32'(m_busy && m_store));
        checkOutput("bus_addr", bus.bus_addr, m_busy ? {m_addr[31:2], 2'b00} : 32'd0);
        checkOutput("bus_wdata", bus.bus_wdata, m_busy ? m_wdata : 32'd0);
        checkOutput("bus_wstrb", 32'(bus.bus_wstrb), m_busy ? 32'(m_wstrb) : 32'd0);
    end

    // Per-access observations captured by applyMemStimulus.
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [3:0]  capWstrb;
    logic        capWe;
    int          reqCycles;
    int          busyCycles;
    int          pulses;

    // One non-memory instruction; returns at the negedge where its writeback is visible.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] alu);
        @(negedge clk);
        in_valid = 1'b1; opcode_i = op; funct3_i = f3; rd_i = rd; alu_out = alu;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One memory instruction; ack is raised during REQ cycle ackCycle (0 = never),
    // and the task spends nCycles negedges after accept before the final negedge.
    task automatic applyMemStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                    input logic [31:0] addr, input logic [31:0] rs2,
                                    input logic [31:0] rdata, input int ackCycle, input int nCycles);
        @(negedge clk);
        in_valid = 1'b1; opcode_i = op; funct3_i = f3; rd_i = rd; alu_out = addr;
        rs2_data_i = rs2; bus.bus_rdata = rdata;
        reqCycles = 0; busyCycles = 0;
        capAddr = 0; capWdata = 0; capWstrb = 0; capWe = 0;
        for (int c = 1; c <= nCycles; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 1) begin
                capAddr = bus.bus_addr; capWdata = bus.bus_wdata;
                capWstrb = bus.bus_wstrb; capWe = bus.bus_we;
            end
            if (bus.bus_req) reqCycles++;
            if (!in_ready) busyCycles++;
            bus.bus_ack = (c == ackCycle);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bus.bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_out = 0; opcode_i = 0; funct3_i = 0; rd_i = 0;
        rs2_data_i = 0; bus.bus_ack = 1'b0; bus.bus_rdata = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset bus_req", 32'(bus.bus_req), 32'd0);
        rst = 1'b0;

        applyStimulus(OP_IMM, 3'b000, 5'd5, 32'h0000_0010);
        checkOutput("addi wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("addi wb_we", 32'(wb_we), 32'd1);
        checkOutput("addi wb_rd", 32'(wb_rd), 32'd5);
        checkOutput("addi wb_data", wb_data, 32'h10);

        applyStimulus(OP_BR, 3'b000, 5'd3, 32'h0000_0044);
        checkOutput("branch wb_we", 32'(wb_we), 32'd0);
        applyStimulus(OP_IMM, 3'b000, 5'd0, 32'h0000_0099);
        checkOutput("rd0 wb_we", 32'(wb_we), 32'd0);

        pulses = 0;
        @(negedge clk);
        in_valid = 1'b1; opcode_i = OP_REG; rd_i = 5'd1; alu_out = 32'h111;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) begin rd_i = 5'(i + 1); alu_out = 32'h111 * (i + 1); end
            else in_valid = 1'b0;
            if (wb_valid) pulses++;
        end
        checkOutput("back-to-back pulses", 32'(pulses), 32'd3);

        applyMemStimulus(OP_LOAD, 3'b000, 5'd6, 32'h0000_1003, 0, 32'h80FF_FF00, 2, 2);
        checkOutput("lb bus_addr", capAddr, 32'h0000_1000);
        checkOutput("lb bus_wstrb", 32'(capWstrb), 32'd0);
        checkOutput("lb busy cycles", 32'(busyCycles), 32'd2);
        checkOutput("lb wb_data", wb_data, 32'hFFFF_FF80);
        checkOutput("lb wb_we", 32'(wb_we), 32'd1);

        applyMemStimulus(OP_LOAD, 3'b100, 5'd6, 32'h0000_1003, 0, 32'h80FF_FF00, 2, 2);
        checkOutput("lbu wb_data", wb_data, 32'h0000_0080);

        applyMemStimulus(OP_LOAD, 3'b001, 5'd9, 32'h0000_1002, 0, 32'h8001_7FFF, 1, 1);
        checkOutput("lh wb_data", wb_data, 32'hFFFF_8001);

        applyMemStimulus(OP_STORE, 3'b001, 5'd0, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 1);
        checkOutput("sh bus_we", 32'(capWe), 32'd1);
        checkOutput("sh bus_wstrb", 32'(capWstrb), 32'b1100);
        checkOutput("sh bus_wdata", capWdata, 32'hABCD_ABCD);
        checkOutput("sh wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("sh wb_we", 32'(wb_we), 32'd0);

        applyMemStimulus(OP_STORE, 3'b000, 5'd0, 32'h0000_2001, 32'h0000_005A, 0, 1, 1);
        checkOutput("sb bus_wstrb", 32'(capWstrb), 32'b0010);
        checkOutput("sb bus_wdata", capWdata, 32'h5A5A_5A5A);

        applyMemStimulus(OP_LOAD, 3'b010, 5'd8, 32'h0000_3001, 0, 0, 0, 0);
        checkOutput("misaligned bus_req", 32'(bus.bus_req), 32'd0);
        checkOutput("misaligned wb_err", 32'(wb_err), 32'd1);
        checkOutput("misaligned wb_we", 32'(wb_we), 32'd0);
        checkOutput("misaligned wb_data", wb_data, 32'h0000_3001);

        applyMemStimulus(OP_LOAD, 3'b011, 5'd8, 32'h0000_3000, 0, 0, 0, 0);
        checkOutput("bad funct3 wb_err", 32'(wb_err), 32'd1);
        checkOutput("bad funct3 wb_data", wb_data, 32'h0000_3000);

        applyMemStimulus(OP_STORE, 3'b010, 5'd0, 32'h0000_4000, 32'hCAFE_F00D, 0, 0, TO);
        checkOutput("timeout req cycles", 32'(reqCycles), 32'(TO));
        checkOutput("timeout sw wstrb", 32'(capWstrb), 32'b1111);
        checkOutput("timeout wb_err", 32'(wb_err), 32'd1);
        checkOutput("timeout in_ready", 32'(in_ready), 32'd1);
        checkOutput("timeout bus_req", 32'(bus.bus_req), 32'd0);
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        checkOutput("late ack wb_valid", 32'(wb_valid), 32'd0);

        applyMemStimulus(OP_LOAD, 3'b010, 5'd7, 32'h0000_5000, 0, 32'hDEAD_BEEF, TO, TO);
        checkOutput("ack at expiry wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("ack at expiry wb_err", 32'(wb_err), 32'd0);
        checkOutput("ack at expiry wb_data", wb_data, 32'hDEAD_BEEF);

        @(negedge clk);
        in_valid = 1'b1; opcode_i = OP_STORE; funct3_i = 3'b010; rd_i = 0;
        alu_out = 32'h0000_6000; rs2_data_i = 32'h0BAD_CAFE;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre-reset bus_req", 32'(bus.bus_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset bus_req", 32'(bus.bus_req), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid) pulses++;
        end
        checkOutput("post-reset pulses", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
